// File: rtl/obstacle_spawner_if.sv
// Interface bundling the control inputs and the slot read port of the
// obstacle spawner. The game controller side drives the master modport;
// the spawner itself uses the slave modport.
interface obstacle_spawner_if;
   logic        enable;
   logic        clear;
   logic        frame_tick;
   logic [10:0] rand_num;
   logic [2:0]  rd_idx;
   logic        rd_active;
   logic [9:0]  rd_x;
   logic [10:0] rd_y;
   logic        spawn_pulse;
   logic        busy;
   logic        tick_drop;

   modport master (
      output enable, clear, frame_tick, rand_num, rd_idx,
      input  rd_active, rd_x, rd_y, spawn_pulse, busy, tick_drop
   );

   modport slave (
      input  enable, clear, frame_tick, rand_num, rd_idx,
      output rd_active, rd_x, rd_y, spawn_pulse, busy, tick_drop
   );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle spawner for the Running Pig game.
// Keeps SLOTS obstacle slots. Once per accepted frame tick it walks the
// slots one per cycle, scrolling active obstacles left and retiring those
// at the left edge, then spends one cycle deciding whether to place a new
// obstacle at the right edge at a random vertical position.
module obstacle_spawner #(
   parameter int SLOTS     = 4,
   parameter int Y_RANGE   = 479,
   parameter int X_START   = 640,
   parameter int SPEED     = 2,
   parameter int SPAWN_GAP = 60
) (
   input  logic               clk,
   input  logic               rst_n,
   obstacle_spawner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOVE  = 2'd1,
      SPAWN = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [2:0]  idx;
   logic [6:0]  gap_cnt;
   logic        spawn_pulse_r;
   logic        tick_drop_r;

   logic [SLOTS-1:0] slot_act;
   logic [9:0]       slot_x [SLOTS];
   logic [10:0]      slot_y [SLOTS];

   logic        free_found;
   logic [2:0]  free_idx;
   logic [10:0] spawn_y;
   logic [6:0]  gap_reload;

   // The generator should stay below Y_RANGE, but an out-of-range value is
   // folded back into the screen rather than trusted.
   assign spawn_y    = (bus.rand_num >= 11'(Y_RANGE)) ? bus.rand_num - 11'(Y_RANGE)
                                                     : bus.rand_num;
   assign gap_reload = 7'(SPAWN_GAP) + {2'b00, bus.rand_num[4:0]};

   assign bus.busy        = (state != IDLE);
   assign bus.spawn_pulse = spawn_pulse_r;
   assign bus.tick_drop   = tick_drop_r;

   // Lowest-index free slot; scanning downward lets the lowest index win.
   always_comb begin
      free_found = 1'b0;
      free_idx   = 3'd0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
         if (!slot_act[s]) begin
            free_found = 1'b1;
            free_idx   = 3'(s);
         end
      end
   end

   // Indexed read port; indices past the last slot read as an empty slot.
   always_comb begin
      bus.rd_active = 1'b0;
      bus.rd_x      = 10'd0;
      bus.rd_y      = 11'd0;
      for (int s = 0; s < SLOTS; s++) begin
         if (bus.rd_idx == 3'(s)) begin
            bus.rd_active = slot_act[s];
            bus.rd_x      = slot_x[s];
            bus.rd_y      = slot_y[s];
         end
      end
   end

   // State register: clear forces IDLE, enable low freezes the sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (bus.clear) begin
         state <= IDLE;
      end else if (bus.enable) begin
         state <= next_state;
      end
   end

   // Next-state: a tick starts the slot walk, the last slot leads to the
   // spawn decision, and the spawn decision always takes one cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.frame_tick) next_state = MOVE;
         MOVE:    if (idx == 3'(SLOTS - 1)) next_state = SPAWN;
         SPAWN:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Slot storage, walk counter and spawn gap. Movement happens one slot per
   // MOVE cycle so a slot retired here is already free when SPAWN looks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx           <= 3'd0;
         gap_cnt       <= 7'(SPAWN_GAP);
         spawn_pulse_r <= 1'b0;
         slot_act      <= '0;
         for (int s = 0; s < SLOTS; s++) begin
            slot_x[s] <= 10'd0;
            slot_y[s] <= 11'd0;
         end
      end else begin
         spawn_pulse_r <= 1'b0;
         if (bus.clear) begin
            idx      <= 3'd0;
            gap_cnt  <= 7'(SPAWN_GAP);
            slot_act <= '0;
            for (int s = 0; s < SLOTS; s++) begin
               slot_x[s] <= 10'd0;
               slot_y[s] <= 11'd0;
            end
         end else if (bus.enable) begin
            case (state)
               IDLE: begin
                  idx <= 3'd0;
               end
               MOVE: begin
                  for (int s = 0; s < SLOTS; s++) begin
                     if (idx == 3'(s) && slot_act[s]) begin
                        if (slot_x[s] < 10'(SPEED)) begin
                           slot_act[s] <= 1'b0;
                        end else begin
                           slot_x[s] <= slot_x[s] - 10'(SPEED);
                        end
                     end
                  end
                  idx <= idx + 3'd1;
               end
               SPAWN: begin
                  if (gap_cnt != 7'd0) begin
                     gap_cnt <= gap_cnt - 7'd1;
                  end else if (free_found) begin
                     for (int s = 0; s < SLOTS; s++) begin
                        if (free_idx == 3'(s)) begin
                           slot_act[s] <= 1'b1;
                           slot_x[s]   <= 10'(X_START);
                           slot_y[s]   <= spawn_y;
                        end
                     end
                     gap_cnt       <= gap_reload;
                     spawn_pulse_r <= 1'b1;
                  end
               end
               default: begin
                  idx <= 3'd0;
               end
            endcase
         end
      end
   end

   // Flag a tick that arrives while an update is running or the game is
   // paused; a tick swallowed by clear is not reported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_drop_r <= 1'b0;
      end else begin
         tick_drop_r <= bus.frame_tick && !bus.clear &&
                        ((state != IDLE) || !bus.enable);
      end
   end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumer of the free-running random value for the Running Pig game.
- Samples an 11-bit random number (0..478) to place obstacles at random vertical positions at the right screen edge.
- Scrolls active obstacles left once per frame and retires them at the left edge.
- Sits between the random generator and the renderer/collision logic, which read obstacle slots through an indexed read port.

Parameters:
- SLOTS, 4, number of obstacle slots (2..8).
- Y_RANGE, 479, valid y range is 0..Y_RANGE-1.
- X_START, 640, x position loaded on spawn.
- SPEED, 2, pixels subtracted from x per frame.
- SPAWN_GAP, 60, minimum frames between spawns.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  game running; when low, all state is held.
- clear  in  1  synchronous clear of all slots (new game).
- frame_tick  in  1  one-cycle pulse per video frame.
- rand_num  in  11  random value from the generator.
- rd_idx  in  3  slot index for the read port.
- rd_active  out  1  slot rd_idx occupied.
- rd_x  out  10  x of slot rd_idx.
- rd_y  out  11  y of slot rd_idx.
- spawn_pulse  out  1  one-cycle pulse when a slot is filled.
- busy  out  1  frame update in progress.
- tick_drop  out  1  one-cycle pulse when a frame_tick is ignored.

Behaviour:
- Reset (async, rst_n low):
  - All slots inactive, x=0, y=0.
  - gap_cnt=SPAWN_GAP, FSM=IDLE.
  - spawn_pulse, busy and tick_drop all 0.
- Read port:
  - Combinational from the slot registers.
  - rd_idx >= SLOTS returns active=0, x=0, y=0.
- FSM states: IDLE, MOVE, SPAWN.
  - IDLE: on frame_tick with enable=1, set slot counter i=0 and go to MOVE. busy=1 from the next cycle.
  - MOVE: one slot per cycle, i=0..SLOTS-1.
    - Active slot with x < SPEED becomes inactive.
    - Any other active slot: x <= x-SPEED.
    - Inactive slots are unchanged.
    - After slot SLOTS-1, go to SPAWN.
  - SPAWN: one cycle, then IDLE with busy=0.
    - If gap_cnt != 0, decrement gap_cnt.
    - Else if a free slot exists: fill the lowest-index free slot with x=X_START and y=rand_num sampled this cycle, pulse spawn_pulse, and set gap_cnt = SPAWN_GAP + rand_num[4:0].
    - Else (no free slot): gap_cnt stays 0 and the spawn retries next frame.
  - busy is high for exactly SLOTS+1 cycles per accepted tick.
- Y clamp: if rand_num >= Y_RANGE, y = rand_num - Y_RANGE. The generator never does this, but the clamp is required.
- A slot freed in MOVE is available to SPAWN in the same frame.
- frame_tick while busy=1 or enable=0: ignored and tick_drop pulses. No queuing.
- enable low mid-update: FSM, counters and slots freeze. The update resumes when enable returns high.
- clear = 1 (priority over everything except reset):
  - All slots inactive, gap_cnt=SPAWN_GAP, FSM=IDLE, busy=0.
  - A frame_tick in the same cycle is discarded without tick_drop.
- Arithmetic: gap_cnt is 7 bits (max 60+31=91). x is 10 bits and never underflows because of the retire rule.

Test Plan:
- Reset, then 60 ticks with rand_num=100: no spawn.
- Tick 61: spawn_pulse, slot0 active, x=640, y=100, gap_cnt=60+4=64.
- Single tick timing: busy rises the cycle after frame_tick and stays high 5 cycles (SLOTS=4). A second frame_tick 2 cycles later produces tick_drop=1 and no extra move.
- Retire: slot0 at x=3, SPEED=2.
  - After tick: x=1.
  - Next tick: rd_active=0.
  - Same-frame spawn with gap_cnt=0 fills slot0 again.
- Full slots: 4 active, gap_cnt=0 → no spawn_pulse and gap_cnt remains 0. After the first retire, the spawn happens in that same frame into the freed lowest index.
- Clamp: force rand_num=500 at spawn → y=21. rand_num=478 → y=478.
- Mid-update control:
  - clear asserted in MOVE cycle 2 → all rd_active=0, busy=0 next cycle, gap_cnt=60.
  - enable dropped in MOVE for 3 cycles → slot x values unchanged until resume, final x each reduced by exactly 2.
